// File: rtl/towns_ini_loader.sv
// towns_ini_loader: packs the HPS ioctl byte stream into 16-bit SDRAM words
// for the TOWNSMiSTer initial-load port. Bytes are paired by word address,
// routed to the ROM or SRAM region by download index, and written one
// request/acknowledge cycle at a time while dl_wait throttles the HPS.
module towns_ini_loader #(
    parameter logic [7:0]  ROM_IDX   = 8'd0,
    parameter logic [7:0]  SRAM_IDX  = 8'd1,
    parameter logic [23:0] ROM_BASE  = 24'h000000,
    parameter logic [23:0] SRAM_BASE = 24'h100000,
    parameter logic [20:0] MAXLEN    = 21'h100000
) (
    input  logic        sysclk,
    input  logic        rstn,
    input  logic        dl_active,
    input  logic [7:0]  dl_index,
    input  logic [20:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        dl_wr,
    output logic        dl_wait,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdat,
    output logic [1:0]  mem_be,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        act_d_reg, act_d_next;
    logic        mapped_reg, mapped_next;
    logic [23:0] base_reg, base_next;
    // Pending low byte waiting for its odd partner
    logic        pend_reg, pend_next;
    logic [19:0] pend_word_reg, pend_word_next;
    logic [7:0]  pend_lo_reg, pend_lo_next;
    // Odd byte queued behind a flush of a different pending word
    logic        q_wr_reg, q_wr_next;
    logic [19:0] q_word_reg, q_word_next;
    logic [7:0]  q_hi_reg, q_hi_next;
    // dl_active fell while a write was in flight
    logic        end_reg, end_next;
    logic        mem_wr_reg, mem_wr_next;
    logic [23:0] mem_addr_reg, mem_addr_next;
    logic [15:0] mem_wdat_reg, mem_wdat_next;
    logic [1:0]  mem_be_reg, mem_be_next;
    logic        dl_wait_reg, dl_wait_next;
    logic        done_reg, done_next;
    logic        ovf_reg, ovf_next;

    // Write launch request built by the next-state logic
    logic        wr_go;
    logic [19:0] wr_word;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [19:0] byte_word;
    logic        ending;

    assign byte_word = dl_addr[20:1];

    assign dl_wait  = dl_wait_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_wdat = mem_wdat_reg;
    assign mem_be   = mem_be_reg;
    assign mem_wr   = mem_wr_reg;
    assign done     = done_reg;
    assign ovf      = ovf_reg;

    // State and datapath registers; reset discards any pending or queued byte
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            act_d_reg     <= 1'b0;
            mapped_reg    <= 1'b0;
            base_reg      <= 24'h0;
            pend_reg      <= 1'b0;
            pend_word_reg <= 20'h0;
            pend_lo_reg   <= 8'h0;
            q_wr_reg      <= 1'b0;
            q_word_reg    <= 20'h0;
            q_hi_reg      <= 8'h0;
            end_reg       <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= 24'h0;
            mem_wdat_reg  <= 16'h0;
            mem_be_reg    <= 2'b00;
            dl_wait_reg   <= 1'b0;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            act_d_reg     <= act_d_next;
            mapped_reg    <= mapped_next;
            base_reg      <= base_next;
            pend_reg      <= pend_next;
            pend_word_reg <= pend_word_next;
            pend_lo_reg   <= pend_lo_next;
            q_wr_reg      <= q_wr_next;
            q_word_reg    <= q_word_next;
            q_hi_reg      <= q_hi_next;
            end_reg       <= end_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdat_reg  <= mem_wdat_next;
            mem_be_reg    <= mem_be_next;
            dl_wait_reg   <= dl_wait_next;
            done_reg      <= done_next;
            ovf_reg       <= ovf_next;
        end
    end

    // Next-state logic: byte packing, write sequencing and end-of-download flush
    always_comb begin
        state_next     = state_reg;
        act_d_next     = dl_active;
        mapped_next    = mapped_reg;
        base_next      = base_reg;
        pend_next      = pend_reg;
        pend_word_next = pend_word_reg;
        pend_lo_next   = pend_lo_reg;
        q_wr_next      = q_wr_reg;
        q_word_next    = q_word_reg;
        q_hi_next      = q_hi_reg;
        end_next       = end_reg;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdat_next  = mem_wdat_reg;
        mem_be_next    = mem_be_reg;
        dl_wait_next   = dl_wait_reg;
        done_next      = done_reg;
        ovf_next       = ovf_reg;
        wr_go          = 1'b0;
        wr_word        = byte_word;
        wr_data        = 16'h0;
        wr_be          = 2'b00;
        ending         = end_reg || !dl_active;

        case (state_reg)
            IDLE, DONE: begin
                if (dl_active && !act_d_reg) begin
                    mapped_next = (dl_index == ROM_IDX) || (dl_index == SRAM_IDX);
                    base_next   = (dl_index == SRAM_IDX) ? SRAM_BASE : ROM_BASE;
                    done_next   = 1'b0;
                    ovf_next    = 1'b0;
                    pend_next   = 1'b0;
                    q_wr_next   = 1'b0;
                    end_next    = 1'b0;
                    state_next  = COLLECT;
                end
            end

            COLLECT: begin
                if (dl_wr) begin
                    if (mapped_reg && (dl_addr < MAXLEN)) begin
                        if (!dl_addr[0]) begin
                            // Even byte: a pending byte of another word must go out first
                            if (pend_reg && (pend_word_reg != byte_word)) begin
                                wr_go      = 1'b1;
                                wr_word    = pend_word_reg;
                                wr_data    = {8'h00, pend_lo_reg};
                                wr_be      = 2'b01;
                                state_next = FLUSH;
                            end
                            pend_next      = 1'b1;
                            pend_word_next = byte_word;
                            pend_lo_next   = dl_data;
                        end else if (pend_reg && (pend_word_reg == byte_word)) begin
                            wr_go      = 1'b1;
                            wr_data    = {dl_data, pend_lo_reg};
                            wr_be      = 2'b11;
                            pend_next  = 1'b0;
                            state_next = WRITE;
                        end else if (pend_reg) begin
                            // Flush the stale low byte, queue this high byte behind it
                            wr_go       = 1'b1;
                            wr_word     = pend_word_reg;
                            wr_data     = {8'h00, pend_lo_reg};
                            wr_be       = 2'b01;
                            pend_next   = 1'b0;
                            q_wr_next   = 1'b1;
                            q_word_next = byte_word;
                            q_hi_next   = dl_data;
                            state_next  = FLUSH;
                        end else begin
                            wr_go      = 1'b1;
                            wr_data    = {dl_data, 8'h00};
                            wr_be      = 2'b10;
                            state_next = WRITE;
                        end
                    end else if (mapped_reg) begin
                        ovf_next = 1'b1;
                    end
                end
                // End of download: the byte of this cycle is already accounted for
                if (!dl_active) begin
                    if (wr_go) begin
                        end_next = 1'b1;
                    end else if (pend_next) begin
                        wr_go      = 1'b1;
                        wr_word    = pend_word_next;
                        wr_data    = {8'h00, pend_lo_next};
                        wr_be      = 2'b01;
                        pend_next  = 1'b0;
                        end_next   = 1'b1;
                        state_next = FLUSH;
                    end else begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end

            WRITE, FLUSH: begin
                if (dl_wr) begin
                    ovf_next = 1'b1;
                end
                if (!dl_active) begin
                    end_next = 1'b1;
                end
                if (mem_ack && mem_wr_reg) begin
                    if (q_wr_reg) begin
                        wr_go      = 1'b1;
                        wr_word    = q_word_reg;
                        wr_data    = {q_hi_reg, 8'h00};
                        wr_be      = 2'b10;
                        q_wr_next  = 1'b0;
                        state_next = WRITE;
                    end else if (ending && pend_reg) begin
                        wr_go      = 1'b1;
                        wr_word    = pend_word_reg;
                        wr_data    = {8'h00, pend_lo_reg};
                        wr_be      = 2'b01;
                        pend_next  = 1'b0;
                        end_next   = 1'b1;
                        state_next = FLUSH;
                    end else begin
                        mem_wr_next  = 1'b0;
                        dl_wait_next = 1'b0;
                        if (ending) begin
                            done_next  = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = COLLECT;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (wr_go) begin
            mem_wr_next   = 1'b1;
            dl_wait_next  = 1'b1;
            mem_addr_next = base_reg + {4'h0, wr_word};
            mem_wdat_next = wr_data;
            mem_be_next   = wr_be;
        end
    end

endmodule
